// File: rtl/spi_rx_framer_pkg.sv
// rtl/spi_rx_framer_pkg.sv - shared SPI receive framer constants and state encoding
package spi_rx_framer_pkg;

    localparam int FRAME_BITS_DEF  = 40;
    localparam int STATUS_BITS_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        WAIT_CS = 2'd2
    } rx_state_e;

endpackage

// File: rtl/spi_rx_framer_if.sv
// rtl/spi_rx_framer_if.sv - serial input and framed output bundle of the SPI receive framer
interface spi_rx_framer_if
    import spi_rx_framer_pkg::*;
#(
    parameter int FRAME_BITS  = FRAME_BITS_DEF,
    parameter int STATUS_BITS = STATUS_BITS_DEF
);

    logic                              bit_in;
    logic                              bit_valid_in;
    logic                              cs_n_in;
    logic                              ready_in;
    logic                              clear_in;
    logic                              valid_out;
    logic [STATUS_BITS-1:0]            status_out;
    logic [FRAME_BITS-STATUS_BITS-1:0] data_out;
    logic                              overrun_out;
    logic                              frame_err_out;

    modport master (
        output bit_in, bit_valid_in, cs_n_in, ready_in, clear_in,
        input  valid_out, status_out, data_out, overrun_out, frame_err_out
    );

    modport slave (
        input  bit_in, bit_valid_in, cs_n_in, ready_in, clear_in,
        output valid_out, status_out, data_out, overrun_out, frame_err_out
    );

endinterface

// File: rtl/spi_rx_shift.sv
// rtl/spi_rx_shift.sv - LSB-first receive shift register with synchronous clear and enable
module spi_rx_shift
    import spi_rx_framer_pkg::*;
#(
    parameter int WIDTH = FRAME_BITS_DEF
) (
    input  logic             clk_in,
    input  logic             reset_n_in,
    input  logic             clr_in,
    input  logic             en_in,
    input  logic             data_in,
    output logic [WIDTH-1:0] r_data_out
);

    // Shifting right means the first bit ends up in bit 0 once WIDTH bits are in.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_data_out <= '0;
        end else if (clr_in) begin
            r_data_out <= '0;
        end else if (en_in) begin
            r_data_out <= {data_in, r_data_out[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/spi_rx_framer.sv
// rtl/spi_rx_framer.sv - collects SPI MISO bits into status/data frames with overrun and short-frame reporting
module spi_rx_framer
    import spi_rx_framer_pkg::*;
#(
    parameter int FRAME_BITS  = FRAME_BITS_DEF,
    parameter int STATUS_BITS = STATUS_BITS_DEF
) (
    input  logic           clk_in,
    input  logic           reset_n_in,
    spi_rx_framer_if.slave rx
);

    localparam int DATA_BITS = FRAME_BITS - STATUS_BITS;
    localparam int CNT_W     = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);

    rx_state_e              state_q;
    rx_state_e              state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic                   shift_clr;
    logic                   shift_en;
    logic                   frame_done_d;
    logic                   frame_done_q;
    logic                   frame_err_d;
    logic [FRAME_BITS-1:0]  shift_data;
    logic                   load;
    logic                   overrun_evt;

    logic                   valid_q;
    logic [STATUS_BITS-1:0] status_q;
    logic [DATA_BITS-1:0]   data_q;
    logic                   overrun_q;
    logic                   frame_err_q;

    spi_rx_shift #(
        .WIDTH (FRAME_BITS)
    ) u_shift (
        .clk_in     (clk_in),
        .reset_n_in (reset_n_in),
        .clr_in     (shift_clr),
        .en_in      (shift_en),
        .data_in    (rx.bit_in),
        .r_data_out (shift_data)
    );

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Chip-select release outranks a coincident strobe, so that bit never counts.
    always_comb begin
        state_d      = state_q;
        shift_clr    = 1'b0;
        shift_en     = 1'b0;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx.cs_n_in) begin
                    state_d   = SHIFT;
                    shift_clr = 1'b1;
                end
            end
            SHIFT: begin
                if (rx.cs_n_in) begin
                    state_d     = IDLE;
                    frame_err_d = (cnt_q != '0);
                end else if (rx.bit_valid_in) begin
                    shift_en = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        frame_done_d = 1'b1;
                        state_d      = WAIT_CS;
                    end
                end
            end
            WAIT_CS: begin
                if (rx.cs_n_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            cnt_q <= '0;
        end else if (shift_clr) begin
            cnt_q <= '0;
        end else if (shift_en) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // The completed frame is handed over one edge after its last bit is shifted in.
    assign load        = frame_done_q && (!valid_q || rx.ready_in);
    assign overrun_evt = frame_done_q && !load;

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            valid_q      <= 1'b0;
            status_q     <= '0;
            data_q       <= '0;
            overrun_q    <= 1'b0;
        end else begin
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            if (load) begin
                valid_q  <= 1'b1;
                status_q <= shift_data[FRAME_BITS-1:DATA_BITS];
                data_q   <= shift_data[DATA_BITS-1:0];
            end else if (rx.ready_in) begin
                valid_q  <= 1'b0;
            end
            if (overrun_evt) begin
                overrun_q <= 1'b1;
            end else if (rx.clear_in) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign rx.valid_out     = valid_q;
    assign rx.status_out    = status_q;
    assign rx.data_out      = data_q;
    assign rx.overrun_out   = overrun_q;
    assign rx.frame_err_out = frame_err_q;

endmodule

// File: doc/spi_rx_framer.md
SPI_RX_FRAMER -- requirements
Module: spi_rx_framer

Interface
REQ-001 Parameter FRAME_BITS, default 40, SHALL set the total bits per frame.
REQ-002 Parameter STATUS_BITS, default 8, SHALL set the width of the status field (upper frame bits).
REQ-003 clk_in  input  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-004 reset_n_in  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 bit_in  input  1  SHALL be the serial data sample (MISO).
REQ-006 bit_valid_in  input  1  SHALL be a one-cycle strobe: sample bit_in this cycle.
REQ-007 cs_n_in  input  1  SHALL be the frame delimiter, active low.
REQ-008 ready_in  input  1  SHALL be the consumer ready signal.
REQ-009 clear_in  input  1  SHALL clear overrun_out synchronously.
REQ-010 valid_out  output  1  SHALL indicate that status_out/data_out hold an unconsumed frame.
REQ-011 status_out  output  STATUS_BITS  SHALL be frame bits [FRAME_BITS-1 : FRAME_BITS-STATUS_BITS].
REQ-012 data_out  output  FRAME_BITS-STATUS_BITS  SHALL be frame bits [FRAME_BITS-STATUS_BITS-1 : 0].
REQ-013 overrun_out  output  1  SHALL be a sticky flag: a complete frame was dropped.
REQ-014 frame_err_out  output  1  SHALL pulse for one cycle when a frame is terminated short.

Function
REQ-015 FSM states SHALL be IDLE, SHIFT and WAIT_CS.
REQ-016 IDLE -> SHIFT SHALL occur on the first edge at which cs_n_in is low; the bit counter and shift register SHALL clear on entry.
REQ-017 In SHIFT, each bit_valid_in SHALL shift bit_in into the register and increment the counter; the first received bit SHALL land in frame bit 0 (LSB-first).
REQ-018 A strobe on the edge at which the count reaches FRAME_BITS SHALL complete the frame, and the FSM SHALL enter WAIT_CS.
REQ-019 At the next edge (latency: 1 cycle after the final strobe edge), the frame SHALL load into the output register if valid_out is low or ready_in is high; otherwise overrun_out SHALL set and the frame SHALL be discarded.
REQ-020 In WAIT_CS, bit_valid_in SHALL be ignored; cs_n_in high SHALL return the FSM to IDLE.
REQ-021 cs_n_in high in SHIFT with count < FRAME_BITS SHALL pulse frame_err_out for one cycle, discard the partial frame and return to IDLE; count 0 SHALL produce no error.
REQ-022 When bit_valid_in and cs_n_in high coincide, cs_n_in SHALL have priority and the bit SHALL be dropped.
REQ-023 bit_valid_in while in IDLE SHALL be ignored.
REQ-024 valid_out SHALL stay high, with status_out/data_out stable, until an edge with ready_in high; it SHALL then clear unless a new frame loads on that same edge.
REQ-025 clear_in and an overrun event on the same edge SHALL leave overrun_out set.
REQ-026 The bit counter SHALL be clog2(FRAME_BITS+1) bits wide and SHALL never wrap.

Reset
REQ-027 Reset assertion SHALL immediately force IDLE and set valid_out, status_out, data_out, overrun_out, frame_err_out, the counter and the shift register to 0, including mid-frame.
REQ-028 After reset release, the first frame SHALL start only at a cs_n_in low sample.

Structure
REQ-029 FRAME_BITS/STATUS_BITS defaults and the state encodings SHALL reside in the shared SPI constants include.
REQ-030 The shift register with enable SHALL be a sub-module named spi_rx_shift (ports clk_in, reset_n_in, clr_in, en_in, data_in, r_data_out); the FSM, counter and output register SHALL stay in the top module.

Verification
REQ-031 Frame 0x12DEADBEEF sent LSB-first, 40 strobes spaced 3 cycles apart, ready_in high -> valid_out high 1 cycle after the 40th strobe edge, status_out 0x12, data_out 0xDEADBEEF.
REQ-032 cs_n_in high after 20 strobes -> frame_err_out high for exactly 1 cycle, valid_out stays 0, next full frame 0xA5_01234567 is received correctly.
REQ-033 ready_in low, two frames 0x0100000001 then 0x0200000002 -> outputs hold 0x01/0x00000001, overrun_out = 1; clear_in -> overrun_out = 0.
REQ-034 45 strobes within a single cs_n_in low window -> exactly one frame is output, strobes 41-45 are ignored, no error.
REQ-035 Reset asserted after 17 bits -> all outputs 0 immediately; after release, frame 0xFF_FFFFFFFF is received correctly.
REQ-036 Strobe coincident with cs_n_in rising at bit 40 -> frame_err_out pulses and no valid_out.
